nv_nvdla_pdp_rdma_eg_tx: RTL and testbench
==========================================

Name: nv_nvdla_pdp_rdma_eg_tx

Overview:
- Transmitter end of the RDMA-to-PDP-core datapath stream (pdp_rdma2dp_*).
- Takes raw read-return beats (one beat = THROUGHPUT elements) from the RDMA response buffer and walks the programmed cube in a fixed order: width, then height, then surface, then split.
- Appends the 12-bit position/info field to each beat and presents the beat on a valid/ready interface to the PDP core input stage.
- Produces a one-cycle done pulse after the final beat (cube_end) is accepted.

Parameters:
- BWPE, 8, bits per element.
- THROUGHPUT, 8, elements per beat.
- DW, BWPE*THROUGHPUT, data width. Derived; must not be overridden.

Ports:
- nvdla_core_clk  in  1  core clock; the only clock.
- nvdla_core_rst  in  1  reset. Synchronous, active-high.
- reg2dp_op_en  in  1  layer enable. A rising edge starts a layer.
- reg2dp_cube_in_width  in  13  beats per line, minus 1.
- reg2dp_cube_in_height  in  13  lines per surface, minus 1.
- reg2dp_cube_in_surface  in  5  surfaces (channel groups) per split, minus 1.
- reg2dp_split_num  in  8  splits, minus 1.
- rd_pd  in  DW  read-return data beat.
- rd_pvld  in  1  read-return valid.
- rd_prdy  out  1  read-return ready.
- pdp_rdma2dp_pd  out  DW+12  {info[11:0], data[DW-1:0]}.
- pdp_rdma2dp_valid  out  1  output valid.
- pdp_rdma2dp_ready  in  1  output ready.
- rdma_done  out  1  one-cycle pulse when the cube_end beat is accepted downstream.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0, output register empty. Applies on any cycle, including mid-layer; any held beat is discarded.
- op_en edge detect: op_en_d1 is registered. start = reg2dp_op_en & ~op_en_d1.
- Register sampling: in IDLE, start loads shadow copies of width, height, surface and split_num. Register changes during RUN are ignored.
- State IDLE: rd_prdy=0. On start, go to RUN.
- State RUN: rd_prdy = ~last_taken & (~pdp_rdma2dp_valid | pdp_rdma2dp_ready).
  - A beat is taken when rd_pvld & rd_prdy.
  - The output register loads {info, rd_pd} and valid goes to 1 on the next cycle. Latency from taken to valid is 1 cycle.
  - Full throughput, 1 beat/cycle, when ready stays high.
- Output register:
  - Valid stays high and pd stays stable until pdp_rdma2dp_ready.
  - Simultaneous drain and load in the same cycle keeps valid=1 with the new beat.
- Counters: w, h, s, p. A taken beat advances w.
  - w wraps at width and increments h.
  - h wraps at height and increments s.
  - s wraps at surface and increments p.
  - The beat where p equals split_num and all inner counters are at their maxima is the last beat: last_taken is set and no further beats are accepted.
- State DONE (entered after the last beat is taken): wait until the output register drains (valid & ready on the last beat).
  - In that same cycle, rdma_done=1.
  - Next cycle: IDLE, counters cleared, last_taken cleared.
- Info field, computed from counters at take time:
  - [3:0] w[3:0].
  - [6:4] 0.
  - [7] split_end: w, h, s all at max.
  - [8] line_end: w at max.
  - [9] surf_end: w, h at max.
  - [10] reserved 0.
  - [11] cube_end: split_end & p at max.
- A layer end is marked by [11] & [7] both set. Consumers key on exactly this pair.
- Degenerate cube (all fields 0): one beat carrying [11], [9], [8], [7] all set.
- A start seen in RUN or DONE is ignored. The next layer requires op_en to fall and rise again while in IDLE.
- rd_pvld while in IDLE is back-pressured (rd_prdy=0); no data is lost.

Decomposition:
- Shared package (pdp_rdma_pkg):
  - Info-bit index constants: INFO_CUBE_END=11, INFO_SURF_END=9, INFO_LINE_END=8, INFO_SPLIT_END=7.
  - Info width 12.
  - State enum {IDLE, RUN, DONE}.
- One sub-module: nv_nvdla_pdp_rdma_cube_cnt. It holds the w/h/s/p counters with wrap flags and the last-beat detect, given an advance strobe and the shadow registers.
- The pipe register and FSM stay in the top.

Test Plan:
- Width=3, height=1, surface=0, split=0; ready tied 1; 8 beats D0..D7 → 8 output beats, each 1 cycle after its take. line_end on beats 3 and 7; cube_end|split_end|surf_end on beat 7; rdma_done 1 cycle, in the same cycle beat 7 is accepted.
- All fields 0, one beat 0xAB.. → info=0xB80 | w(0) = 0xB80; rdma_done pulses once; state returns to IDLE.
- Width=1, height=0, surface=1, split=1 (8 beats); ready toggles 1010...
  - pd stays stable while valid & ~ready.
  - No beat is dropped or duplicated.
  - split_end on beats 3 and 7; cube_end on beat 7 only.
- rd_pvld held high in IDLE for 5 cycles → rd_prdy=0 and no output. Then an op_en rise → first beat taken the cycle after the start cycle.
- Reset pulsed mid-layer after 3 of 8 beats:
  - Next cycle valid=0, rd_prdy=0, counters 0.
  - A new op_en rise restarts from w=0.
  - No rdma_done from the aborted layer.
- Width changed from 3 to 7 mid-layer, and op_en re-pulsed during RUN → both ignored; layer completes with the original 4-beat lines and exactly one rdma_done.

Source files
------------

// File: rtl/pdp_rdma_pkg.sv
// Shared definitions for the PDP RDMA egress transmitter.
// Info-field bit positions, info width and the transmitter FSM state type.
package pdp_rdma_pkg;
  localparam int INFO_W         = 12;
  localparam int INFO_CUBE_END  = 11;
  localparam int INFO_SURF_END  = 9;
  localparam int INFO_LINE_END  = 8;
  localparam int INFO_SPLIT_END = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/nv_nvdla_pdp_rdma_cube_cnt.sv
// Cube position counters for the RDMA egress walk (width, height, surface,
// split order).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clr             : return all counters to 0 (end of layer)
//   adv             : one beat consumed, advance the walk
//   width..split    : shadowed cube extents (each is count minus 1)
//   w/h/s/p         : current position
//   *_max           : counter sits at its programmed maximum
//   last            : current position is the final beat of the cube
module nv_nvdla_pdp_rdma_cube_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        adv,
  input  logic [12:0] width,
  input  logic [12:0] height,
  input  logic [4:0]  surface,
  input  logic [7:0]  split,
  output logic [12:0] w,
  output logic [12:0] h,
  output logic [4:0]  s,
  output logic [7:0]  p,
  output logic        w_max,
  output logic        h_max,
  output logic        s_max,
  output logic        p_max,
  output logic        last
);
  logic [12:0] w_q, w_d, h_q, h_d;
  logic [4:0]  s_q, s_d;
  logic [7:0]  p_q, p_d;

  assign w     = w_q;
  assign h     = h_q;
  assign s     = s_q;
  assign p     = p_q;
  assign w_max = (w_q == width);
  assign h_max = (h_q == height);
  assign s_max = (s_q == surface);
  assign p_max = (p_q == split);
  assign last  = w_max & h_max & s_max & p_max;

  // Ripple-carry style nesting: each inner wrap carries into the next level.
  always_comb begin
    w_d = w_q;
    h_d = h_q;
    s_d = s_q;
    p_d = p_q;
    if (clr) begin
      w_d = '0;
      h_d = '0;
      s_d = '0;
      p_d = '0;
    end else if (adv) begin
      if (w_max) begin
        w_d = '0;
        if (h_max) begin
          h_d = '0;
          if (s_max) begin
            s_d = '0;
            p_d = p_max ? 8'd0 : p_q + 8'd1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end else begin
          h_d = h_q + 13'd1;
        end
      end else begin
        w_d = w_q + 13'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
      h_q <= '0;
      s_q <= '0;
      p_q <= '0;
    end else begin
      w_q <= w_d;
      h_q <= h_d;
      s_q <= s_d;
      p_q <= p_d;
    end
  end
endmodule

// File: rtl/nv_nvdla_pdp_rdma_eg_tx.sv
// RDMA egress transmitter: walks the programmed cube, tags every read-return
// beat with a 12-bit position/info field and presents {info, data} to the
// PDP core on a valid/ready interface through a single output register.
// Ports:
//   nvdla_core_clk/rst       : clock, synchronous active-high reset
//   reg2dp_op_en             : layer enable, rising edge starts a layer
//   reg2dp_cube_in_*, split  : cube extents (minus 1), shadowed at start
//   rd_pd/rd_pvld/rd_prdy    : read-return beat input
//   pdp_rdma2dp_*            : tagged beat output
//   rdma_done                : pulse when the cube_end beat is accepted
module nv_nvdla_pdp_rdma_eg_tx
  import pdp_rdma_pkg::*;
#(
  parameter int BWPE       = 8,
  parameter int THROUGHPUT = 8
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rst,
  input  logic                          reg2dp_op_en,
  input  logic [12:0]                   reg2dp_cube_in_width,
  input  logic [12:0]                   reg2dp_cube_in_height,
  input  logic [4:0]                    reg2dp_cube_in_surface,
  input  logic [7:0]                    reg2dp_split_num,
  input  logic [BWPE*THROUGHPUT-1:0]    rd_pd,
  input  logic                          rd_pvld,
  output logic                          rd_prdy,
  output logic [BWPE*THROUGHPUT+11:0]   pdp_rdma2dp_pd,
  output logic                          pdp_rdma2dp_valid,
  input  logic                          pdp_rdma2dp_ready,
  output logic                          rdma_done
);
  localparam int DW = BWPE * THROUGHPUT;

  state_e             state_q, state_d;
  logic               op_en_d1_q;
  logic [12:0]        width_q, width_d, height_q, height_d;
  logic [4:0]         surface_q, surface_d;
  logic [7:0]         split_q, split_d;
  logic               last_taken_q, last_taken_d;
  logic               vld_q, vld_d;
  logic [DW+11:0]     pd_q, pd_d;

  logic               start, take, drain, done_fire;
  logic [INFO_W-1:0]  info;
  logic [12:0]        cw, ch;
  logic [4:0]         cs;
  logic [7:0]         cp;
  logic               w_max, h_max, s_max, p_max, cnt_last;

  nv_nvdla_pdp_rdma_cube_cnt u_cnt (
    .clk     (nvdla_core_clk),
    .rst     (nvdla_core_rst),
    .clr     (done_fire),
    .adv     (take),
    .width   (width_q),
    .height  (height_q),
    .surface (surface_q),
    .split   (split_q),
    .w       (cw),
    .h       (ch),
    .s       (cs),
    .p       (cp),
    .w_max   (w_max),
    .h_max   (h_max),
    .s_max   (s_max),
    .p_max   (p_max),
    .last    (cnt_last)
  );

  assign start     = reg2dp_op_en & ~op_en_d1_q;
  assign drain     = vld_q & pdp_rdma2dp_ready;
  // Only the last beat can be in the register while in DONE.
  assign done_fire = (state_q == DONE) & drain & ~nvdla_core_rst;
  assign rd_prdy   = (state_q == RUN) & ~last_taken_q & (~vld_q | pdp_rdma2dp_ready)
                   & ~nvdla_core_rst;
  assign take      = rd_pvld & rd_prdy;

  assign pdp_rdma2dp_pd    = pd_q;
  assign pdp_rdma2dp_valid = vld_q;
  assign rdma_done         = done_fire;

  always_comb begin
    info                 = '0;
    info[3:0]            = cw[3:0];
    info[INFO_SPLIT_END] = w_max & h_max & s_max;
    info[INFO_LINE_END]  = w_max;
    info[INFO_SURF_END]  = w_max & h_max;
    info[INFO_CUBE_END]  = cnt_last;
  end

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    surface_d    = surface_q;
    split_d      = split_q;
    last_taken_d = last_taken_q;
    vld_d        = vld_q;
    pd_d         = pd_q;

    case (state_q)
      IDLE: if (start) begin
        state_d   = RUN;
        width_d   = reg2dp_cube_in_width;
        height_d  = reg2dp_cube_in_height;
        surface_d = reg2dp_cube_in_surface;
        split_d   = reg2dp_split_num;
      end
      RUN:  if (take && cnt_last) state_d = DONE;
      DONE: if (drain) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (done_fire)            last_taken_d = 1'b0;
    else if (take && cnt_last) last_taken_d = 1'b1;

    // A load in the same cycle as a drain keeps valid high with the new beat.
    if (take) begin
      vld_d = 1'b1;
      pd_d  = {info, rd_pd};
    end else if (drain) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q      <= IDLE;
      op_en_d1_q   <= 1'b0;
      width_q      <= '0;
      height_q     <= '0;
      surface_q    <= '0;
      split_q      <= '0;
      last_taken_q <= 1'b0;
      vld_q        <= 1'b0;
      pd_q         <= '0;
    end else begin
      state_q      <= state_d;
      op_en_d1_q   <= reg2dp_op_en;
      width_q      <= width_d;
      height_q     <= height_d;
      surface_q    <= surface_d;
      split_q      <= split_d;
      last_taken_q <= last_taken_d;
      vld_q        <= vld_d;
      pd_q         <= pd_d;
    end
  end
endmodule

// File: tb/tb_nv_nvdla_pdp_rdma_eg_tx.sv
module tb_nv_nvdla_pdp_rdma_eg_tx;
  localparam int DW = 64;
  localparam int PW = DW + 12;

  typedef struct packed {
    logic [PW-1:0] pd;
    int            cyc;
  } exp_t;

  logic          clk, rst, op_en, rd_pvld, rd_prdy, valid, ready, done;
  logic [12:0]   width, height;
  logic [4:0]    surface;
  logic [7:0]    split;
  logic [DW-1:0] rd_pd;
  logic [PW-1:0] pd;

  exp_t          exp_q[$];
  logic [11:0]   exp_inf[8];
  logic [7:0]    base;
  int            checks, fails, cyc, done_cnt, last_take;
  bit            tog, lat_chk;

  nv_nvdla_pdp_rdma_eg_tx dut (
    .nvdla_core_clk         (clk),
    .nvdla_core_rst         (rst),
    .reg2dp_op_en           (op_en),
    .reg2dp_cube_in_width   (width),
    .reg2dp_cube_in_height  (height),
    .reg2dp_cube_in_surface (surface),
    .reg2dp_split_num       (split),
    .rd_pd                  (rd_pd),
    .rd_pvld                (rd_pvld),
    .rd_prdy                (rd_prdy),
    .pdp_rdma2dp_pd         (pd),
    .pdp_rdma2dp_valid      (valid),
    .pdp_rdma2dp_ready      (ready),
    .rdma_done              (done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  // Downstream ready: tied high or toggling 1010...
  initial begin
    ready = 1;
    forever begin
      @(posedge clk);
      #1 ready = tog ? ~ready : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    bit hold_prev;
    logic [PW-1:0] pd_prev;
    hold_prev = 0;
    pd_prev = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) done_cnt++;
        if (hold_prev) begin
          chk("hold_valid", PW'(valid), PW'(1));
          chk("hold_pd", pd, pd_prev);
        end
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", pd, '0);
          end else begin
            e = exp_q.pop_front();
            chk("beat_pd", pd, e.pd);
            chk("done_vs_cube_end", PW'(done), PW'(e.pd[PW-1]));
            if (lat_chk) chk("take_to_valid", PW'(cyc), PW'(e.cyc));
          end
        end else if (done) begin
          chk("done_without_accept", PW'(done), PW'(0));
        end
        hold_prev = valid && !ready;
        pd_prev = pd;
      end else begin
        hold_prev = 0;
      end
    end
  end

  task automatic start_layer(output int k0);
    @(posedge clk); #2 op_en = 0;
    @(posedge clk); #2 op_en = 1;
    k0 = cyc;
  endtask

  task automatic send(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      int to;
      to = 0;
      rd_pvld = 1;
      rd_pd = {8{base + 8'(i)}};
      @(negedge clk);
      while (!rd_prdy && to < 60) begin
        @(negedge clk);
        to++;
      end
      if (!rd_prdy) begin
        chk("take_timeout", PW'(0), PW'(1));
        break;
      end
      exp_q.push_back('{pd: {exp_inf[i], rd_pd}, cyc: cyc + 1});
      last_take = cyc + 1;
      @(posedge clk); #2;
    end
    rd_pvld = 0;
  endtask

  task automatic wait_done(input int d0, input int n_done);
    int to;
    to = 0;
    while (exp_q.size() != 0 && to < 200) begin
      @(negedge clk);
      to++;
    end
    repeat (4) @(negedge clk);
    chk("drained", PW'(exp_q.size()), PW'(0));
    chk("done_count", PW'(done_cnt - d0), PW'(n_done));
  endtask

  task automatic set_cfg(input logic [12:0] w, input logic [12:0] h, input logic [4:0] s,
                         input logic [7:0] p);
    width = w; height = h; surface = s; split = p;
  endtask

  task automatic tbl_a;
    exp_inf = '{12'h000, 12'h001, 12'h002, 12'h103, 12'h000, 12'h001, 12'h002, 12'hB83};
  endtask

  initial begin
    int k0, d0;
    checks = 0; fails = 0; done_cnt = 0; last_take = 0;
    tog = 0; lat_chk = 1;
    rst = 1; op_en = 0; rd_pvld = 0; rd_pd = '0; base = 8'hD0;
    set_cfg(0, 0, 0, 0);
    tbl_a();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", PW'(valid), PW'(0));
    chk("rst_prdy", PW'(rd_prdy), PW'(0));
    chk("rst_done", PW'(done), PW'(0));
    chk("rst_pd", pd, '0);
    rst = 0;

    // 1: 4x2 cube, ready tied high
    set_cfg(3, 1, 0, 0); tbl_a(); base = 8'hD0; d0 = done_cnt;
    start_layer(k0);
    send(0, 8);
    wait_done(d0, 1);

    // 2: degenerate single-beat cube
    set_cfg(0, 0, 0, 0); exp_inf[0] = 12'hB80; base = 8'hAB; d0 = done_cnt;
    start_layer(k0);
    send(0, 1);
    wait_done(d0, 1);
    rd_pvld = 1;
    @(negedge clk);
    chk("idle_after_done_prdy", PW'(rd_prdy), PW'(0));
    rd_pvld = 0;

    // 3: 2x1x2 surfaces x2 splits, ready toggling
    set_cfg(1, 0, 1, 1); base = 8'h30; d0 = done_cnt;
    exp_inf = '{12'h000, 12'h301, 12'h000, 12'h381, 12'h000, 12'h301, 12'h000, 12'hB81};
    tog = 1; lat_chk = 0;
    start_layer(k0);
    send(0, 8);
    wait_done(d0, 1);
    tog = 0; lat_chk = 1;
    @(posedge clk); #2;

    // 4: valid held in IDLE is back-pressured, then start
    set_cfg(3, 1, 0, 0); tbl_a(); base = 8'h50; d0 = done_cnt;
    op_en = 0;
    rd_pvld = 1; rd_pd = {8{8'h50}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_prdy", PW'(rd_prdy), PW'(0));
      chk("idle_valid", PW'(valid), PW'(0));
    end
    @(posedge clk); #2 op_en = 1;
    k0 = cyc;
    send(0, 8);
    chk("first_take_cycle", PW'(last_take - 7), PW'(k0 + 2));
    wait_done(d0, 1);

    // 5: reset mid-layer after 3 beats, then restart
    base = 8'h70; d0 = done_cnt;
    start_layer(k0);
    send(0, 3);
    repeat (2) @(posedge clk);
    #2 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", PW'(valid), PW'(0));
    chk("midrst_prdy", PW'(rd_prdy), PW'(0));
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("postrst_prdy", PW'(rd_prdy), PW'(0));
    chk("aborted_no_done", PW'(done_cnt - d0), PW'(0));
    base = 8'h90; d0 = done_cnt;
    start_layer(k0);
    send(0, 8);
    wait_done(d0, 1);

    // 6: width change and op_en re-pulse during RUN are ignored
    set_cfg(3, 1, 0, 0); tbl_a(); base = 8'hC0; d0 = done_cnt;
    start_layer(k0);
    send(0, 4);
    width = 13'd7;
    op_en = 0;
    @(posedge clk); #2 op_en = 1;
    send(4, 4);
    wait_done(d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
